// File: rtl/spidergon_output_arbiter_if.sv
// Requester-side and link-side handshake bundle for one Spidergon output link arbiter.
// master drives requests and credit returns; slave is the arbiter that answers with grants.
interface spidergon_output_arbiter_if #(
  parameter int P  = 4,
  parameter int V  = 2,
  parameter int VW = 1
);
  logic [P-1:0]    req;
  logic [P*VW-1:0] req_vc;
  logic [P-1:0]    req_head;
  logic [P-1:0]    req_tail;
  logic [V-1:0]    credit_in;
  logic [P-1:0]    grant;
  logic            out_valid;
  logic [VW-1:0]   out_vc;

  modport master (
    output req, req_vc, req_head, req_tail, credit_in,
    input  grant, out_valid, out_vc
  );

  modport slave (
    input  req, req_vc, req_head, req_tail, credit_in,
    output grant, out_valid, out_vc
  );
endinterface

// File: rtl/spidergon_output_arbiter.sv
// Output-link arbiter / VC allocator: wormhole lock per VC, credit flow control, round-robin.
// Optional per-port grant counters when SPIDERGON_ARB_STATS_EN is defined.
module spidergon_output_arbiter #(
  parameter int NUM_OF_INPUT_PORTS      = 4,
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int VC_BUFFER_DEPTH         = 2,
  localparam int P  = NUM_OF_INPUT_PORTS,
  localparam int V  = NUM_OF_VIRTUAL_CHANNELS,
  localparam int VW = (V > 1) ? $clog2(V) : 1,
  localparam int PW = (P > 1) ? $clog2(P) : 1,
  localparam int CW = $clog2(VC_BUFFER_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  spidergon_output_arbiter_if.slave     link,
  output logic [V*CW-1:0]               credit_count,
  output logic [V-1:0]                  vc_locked,
  output logic                          credit_overflow
`ifdef SPIDERGON_ARB_STATS_EN
  ,
  output logic [P*16-1:0]               grant_count
`endif
);

  typedef enum logic {
    VC_IDLE,
    VC_LOCKED
  } vc_state_t;

  // VC codes above V-1 (non-power-of-two V) never become eligible
  localparam logic [(2**VW)-1:0] VC_EXISTS = {(2**VW){1'b1}} >> ((2**VW) - V);

  vc_state_t       vc_state      [V];
  vc_state_t       vc_state_next [V];
  logic [PW-1:0]   owner         [V];
  logic [PW-1:0]   owner_next    [V];
  logic [CW-1:0]   credit        [V];
  logic [CW-1:0]   credit_next   [V];
  logic            overflow_next;
  logic [PW-1:0]   rr_ptr;
  logic [VW-1:0]   port_vc       [P];
  logic [P-1:0]    eligible;
  logic            grant_any;
  logic [PW-1:0]   grant_port;
  logic [PW-1:0]   scan_idx;
  logic [VW-1:0]   grant_vc;
  logic [P-1:0]    grant_vec;
  logic [V-1:0]    vc_taken;

  always_comb begin
    for (int p = 0; p < P; p++) begin
      port_vc[p] = link.req_vc[p*VW +: VW];
    end
  end

  // A head may claim an idle VC; only the owner's body/tail flits may use a locked one
  always_comb begin
    eligible = '0;
    for (int p = 0; p < P; p++) begin
      if (link.req[p] && VC_EXISTS[port_vc[p]] && (credit[port_vc[p]] != '0)) begin
        if (vc_state[port_vc[p]] == VC_IDLE) begin
          eligible[p] = link.req_head[p];
        end else begin
          eligible[p] = (owner[port_vc[p]] == PW'(p)) && !link.req_head[p];
        end
      end
    end
  end

  // Scan backwards so the last hit is the first eligible port at or after rr_ptr
  always_comb begin
    grant_any  = 1'b0;
    grant_port = '0;
    scan_idx   = '0;
    for (int i = P - 1; i >= 0; i--) begin
      scan_idx = PW'((int'(rr_ptr) + i) % P);
      if (eligible[scan_idx]) begin
        grant_any  = reset;
        grant_port = scan_idx;
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    grant_vc  = '0;
    vc_taken  = '0;
    if (grant_any) begin
      grant_vec = P'(1) << grant_port;
      grant_vc  = port_vc[grant_port];
    end
    for (int v = 0; v < V; v++) begin
      vc_taken[v] = grant_any && (grant_vc == VW'(v));
    end
  end

  assign link.grant     = grant_vec;
  assign link.out_valid = grant_any;
  assign link.out_vc    = grant_vc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < V; v++) begin
        vc_state[v] <= VC_IDLE;
        owner[v]    <= '0;
      end
    end else begin
      for (int v = 0; v < V; v++) begin
        vc_state[v] <= vc_state_next[v];
        owner[v]    <= owner_next[v];
      end
    end
  end

  always_comb begin
    for (int v = 0; v < V; v++) begin
      vc_state_next[v] = vc_state[v];
      owner_next[v]    = owner[v];
      if (vc_taken[v]) begin
        if (vc_state[v] == VC_IDLE) begin
          if (!link.req_tail[grant_port]) begin
            vc_state_next[v] = VC_LOCKED;
            owner_next[v]    = grant_port;
          end
        end else if (link.req_tail[grant_port]) begin
          vc_state_next[v] = VC_IDLE;
        end
      end
    end
  end

  always_comb begin
    vc_locked = '0;
    for (int v = 0; v < V; v++) begin
      vc_locked[v] = (vc_state[v] == VC_LOCKED);
    end
  end

  // A returned credit and a forwarded flit on the same VC cancel out
  always_comb begin
    overflow_next = credit_overflow;
    for (int v = 0; v < V; v++) begin
      credit_next[v] = credit[v];
      if (link.credit_in[v] && !vc_taken[v]) begin
        if (credit[v] == CW'(VC_BUFFER_DEPTH)) begin
          overflow_next = 1'b1;
        end else begin
          credit_next[v] = credit[v] + CW'(1);
        end
      end else if (vc_taken[v] && !link.credit_in[v]) begin
        credit_next[v] = credit[v] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < V; v++) begin
        credit[v] <= CW'(VC_BUFFER_DEPTH);
      end
      credit_overflow <= 1'b0;
      rr_ptr          <= '0;
    end else begin
      for (int v = 0; v < V; v++) begin
        credit[v] <= credit_next[v];
      end
      credit_overflow <= overflow_next;
      if (grant_any) begin
        rr_ptr <= PW'((int'(grant_port) + 1) % P);
      end
    end
  end

  always_comb begin
    for (int v = 0; v < V; v++) begin
      credit_count[v*CW +: CW] = credit[v];
    end
  end

`ifdef SPIDERGON_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_count <= '0;
    end else begin
      for (int p = 0; p < P; p++) begin
        if (grant_vec[p] && (grant_count[p*16 +: 16] != 16'hFFFF)) begin
          grant_count[p*16 +: 16] <= grant_count[p*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_spidergon_output_arbiter.sv
// Scoreboard bench for spidergon_output_arbiter: stimulus queues expected per-cycle results,
// a negedge monitor pops and compares grants and status.
module tb_spidergon_output_arbiter;

  logic clk;
  logic reset;
  logic [3:0] credit_count;
  logic [1:0] vc_locked;
  logic       credit_overflow;
`ifdef SPIDERGON_ARB_STATS_EN
  logic [63:0] grant_count;
`endif

  spidergon_output_arbiter_if #(.P(4), .V(2), .VW(1)) link_if ();

  spidergon_output_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .link            (link_if),
    .credit_count    (credit_count),
    .vc_locked       (vc_locked),
    .credit_overflow (credit_overflow)
`ifdef SPIDERGON_ARB_STATS_EN
    ,
    .grant_count     (grant_count)
`endif
  );

  typedef struct {
    logic [3:0] grant;
    logic       vc;
    logic [3:0] credits;
    logic [1:0] locked;
    logic       ovf;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e);
    logic want_valid;
    want_valid = |e.grant;
    total++;
    if (link_if.grant !== e.grant || link_if.out_valid !== want_valid || link_if.out_vc !== e.vc) begin
      bad++;
      $display("[TB] FAIL %s grant: got grant=%b valid=%b vc=%0d, want grant=%b valid=%b vc=%0d",
               e.name, link_if.grant, link_if.out_valid, link_if.out_vc, e.grant, want_valid, e.vc);
    end
    total++;
    if (credit_count !== e.credits || vc_locked !== e.locked || credit_overflow !== e.ovf) begin
      bad++;
      $display("[TB] FAIL %s status: got credits=%b locked=%b ovf=%b, want credits=%b locked=%b ovf=%b",
               e.name, credit_count, vc_locked, credit_overflow, e.credits, e.locked, e.ovf);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  // credit encoding: {credit[1], credit[0]} two bits each
  task automatic applyStimulus(input logic rst_val, input logic [3:0] r, input logic [3:0] vcs,
                               input logic [3:0] h, input logic [3:0] t, input logic [1:0] ci,
                               input logic [3:0] eg, input logic ev, input logic [3:0] ec,
                               input logic [1:0] el, input logic eo, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset             = rst_val;
    link_if.req       = r;
    link_if.req_vc    = vcs;
    link_if.req_head  = h;
    link_if.req_tail  = t;
    link_if.credit_in = ci;
    e.grant   = eg;
    e.vc      = ev;
    e.credits = ec;
    e.locked  = el;
    e.ovf     = eo;
    e.name    = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    reset             = 1'b0;
    link_if.req       = '0;
    link_if.req_vc    = '0;
    link_if.req_head  = '0;
    link_if.req_tail  = '0;
    link_if.credit_in = '0;

    // reset held while port 0 requests
    applyStimulus(0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'b00, 4'b0000, 0, 4'b1010, 2'b00, 0, "rst1");
    applyStimulus(0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'b00, 4'b0000, 0, 4'b1010, 2'b00, 0, "rst2");

    // round-robin across all four ports on VC0 with credit returned every cycle
    applyStimulus(1, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 2'b01, 4'b0001, 0, 4'b1010, 2'b00, 0, "rr0");
    applyStimulus(1, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 2'b01, 4'b0010, 0, 4'b1010, 2'b00, 0, "rr1");
    applyStimulus(1, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 2'b01, 4'b0100, 0, 4'b1010, 2'b00, 0, "rr2");
    applyStimulus(1, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 2'b01, 4'b1000, 0, 4'b1010, 2'b00, 0, "rr3");
    applyStimulus(1, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 2'b01, 4'b0001, 0, 4'b1010, 2'b00, 0, "rr4");

    // wormhole lock on VC1 by port 1; port 2 head waits
    applyStimulus(1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 2'b00, 4'b0010, 1, 4'b1010, 2'b00, 0, "lk_head");
    applyStimulus(1, 4'b0110, 4'b0110, 4'b0100, 4'b0000, 2'b10, 4'b0010, 1, 4'b0110, 2'b10, 0, "lk_body");
    applyStimulus(1, 4'b0110, 4'b0110, 4'b0100, 4'b0010, 2'b10, 4'b0010, 1, 4'b0110, 2'b10, 0, "lk_tail");
    applyStimulus(1, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 2'b00, 4'b0100, 1, 4'b0110, 2'b00, 0, "lk_next");
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b10, 4'b0000, 0, 4'b0010, 2'b00, 0, "lk_cr1");
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b10, 4'b0000, 0, 4'b0110, 2'b00, 0, "lk_cr2");

    // VC0 credit exhaustion; VC1 still served while VC0 starves
    applyStimulus(1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'b00, 4'b0001, 0, 4'b1010, 2'b00, 0, "cr_a");
    applyStimulus(1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'b00, 4'b0001, 0, 4'b1001, 2'b00, 0, "cr_b");
    applyStimulus(1, 4'b0101, 4'b0100, 4'b0101, 4'b0101, 2'b00, 4'b0100, 1, 4'b1000, 2'b00, 0, "cr_zero");
    applyStimulus(1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'b01, 4'b0000, 0, 4'b0100, 2'b00, 0, "cr_pulse");
    applyStimulus(1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'b00, 4'b0001, 0, 4'b0101, 2'b00, 0, "cr_after");
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b01, 4'b0000, 0, 4'b0100, 2'b00, 0, "cr_ret1");
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b11, 4'b0000, 0, 4'b0101, 2'b00, 0, "cr_ret2");
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 4'b1010, 2'b00, 0, "cr_full");

    // credit overflow is sticky; simultaneous grant+credit at full is not an overflow
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b10, 4'b0000, 0, 4'b1010, 2'b00, 0, "ov_pulse");
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 4'b1010, 2'b00, 1, "ov_stick");
    applyStimulus(1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 2'b01, 4'b0001, 0, 4'b1010, 2'b00, 1, "ov_both");

    // reset in the middle of a port 3 packet on VC0
    applyStimulus(1, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 2'b00, 4'b1000, 0, 4'b1010, 2'b00, 1, "mr_head");
    applyStimulus(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 2'b01, 4'b1000, 0, 4'b1001, 2'b01, 1, "mr_body");
    applyStimulus(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 4'b1010, 2'b00, 0, "mr_rst");
    applyStimulus(1, 4'b1101, 4'b0100, 4'b0101, 4'b0101, 2'b00, 4'b0001, 0, 4'b1010, 2'b00, 0, "mr_new");
    applyStimulus(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 0, 4'b1001, 2'b00, 0, "mr_orph");

    @(posedge clk);
    #1;
    link_if.req       = '0;
    link_if.credit_in = '0;

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
